rv_fetch_queue: RTL and testbench

Next-generation instruction fetch unit with a parametrised prefetch queue.
- Issues single-outstanding memory read requests with a req/ack handshake.
- Pushes {pc, instruction} pairs into a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap) by flushing the queue and discarding any stale in-flight response.
- Sits between the instruction memory port and the decode stage.

---
 rtl/rv_fetch_queue_pkg.sv | 22 ++
 rtl/rv_fetch_queue_if.sv | 34 +++
 rtl/rv_fetch_queue_fifo.sv | 67 ++++++
 rtl/rv_fetch_queue.sv | 123 ++++++++++++
 tb/tb_rv_fetch_queue.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_queue_pkg.sv
// Shared fetch/decode types for the rv_fetch_queue slice.
// Also holds the fetch FSM state encoding and PC step helper.
package rv_fetch_queue_pkg;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_bus_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        return a + INSN_BYTES;
    endfunction

endpackage

// File: rtl/rv_fetch_queue_if.sv
// Memory-port and decode-side signals of the fetch unit.
// master = fetch unit, slave = memory/decode environment.
interface rv_fetch_queue_if;
    import rv_fetch_queue_pkg::*;

    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_data;
    logic        o_valid;
    logic        i_ready;
    fetch_bus_t  o_bus;

    modport master (
        output o_mem_req,
        output o_mem_addr,
        input  i_mem_ack,
        input  i_mem_data,
        output o_valid,
        input  i_ready,
        output o_bus
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_addr,
        output i_mem_ack,
        output i_mem_data,
        input  o_valid,
        output i_ready,
        input  o_bus
    );

endinterface

// File: rtl/rv_fetch_queue_fifo.sv
// Synchronous prefetch FIFO; flush wins over push and pop.
// Storage is not reset, only pointers and occupancy are.
module rv_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(DEPTH);
    localparam logic [AW-1:0] PONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LIMIT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PONE;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && !flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Instruction fetch unit: single-outstanding memory reads feeding
// a prefetch queue, with redirect flush and stale-response drop.
module rv_fetch_queue
    import rv_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [31:0]       i_pc_target,
    input  logic              i_pc_select,
    rv_fetch_queue_if.master  fq
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   next_pc_q, next_pc_d;
    logic          push, pop;
    logic [CW-1:0] fifo_count, count_next;
    logic          fifo_full, fifo_empty;
    logic [63:0]   fifo_rdata;

    // A redirect cancels both queue sides in the same cycle.
    assign push = (state_q == S_REQ) && fq.i_mem_ack
               && !i_pc_select && !fifo_full;
    assign pop  = !fifo_empty && fq.i_ready && !i_pc_select;

    rv_fetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (i_pc_select),
        .wdata     ({req_addr_q, fq.i_mem_data}),
        .rdata     (fifo_rdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        count_next = fifo_count;
        unique case ({push, pop})
            2'b10:   count_next = fifo_count + ONE;
            2'b01:   count_next = fifo_count - ONE;
            default: count_next = fifo_count;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        next_pc_d  = next_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_pc_select) begin
                    state_d    = S_REQ;
                    req_addr_d = i_pc_target;
                    next_pc_d  = i_pc_target;
                end else if (count_next < DEPTH_C) begin
                    state_d    = S_REQ;
                    req_addr_d = next_pc_q;
                end
            end
            S_REQ: begin
                if (i_pc_select && fq.i_mem_ack) begin
                    req_addr_d = i_pc_target;
                    next_pc_d  = i_pc_target;
                end else if (i_pc_select) begin
                    // The bus cycle must still complete at req_addr.
                    state_d   = S_DROP;
                    next_pc_d = i_pc_target;
                end else if (fq.i_mem_ack) begin
                    next_pc_d = next_addr(req_addr_q);
                    if (count_next < DEPTH_C) begin
                        req_addr_d = next_addr(req_addr_q);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (i_pc_select && fq.i_mem_ack) begin
                    state_d    = S_REQ;
                    req_addr_d = i_pc_target;
                    next_pc_d  = i_pc_target;
                end else if (i_pc_select) begin
                    next_pc_d = i_pc_target;
                end else if (fq.i_mem_ack) begin
                    state_d    = S_REQ;
                    req_addr_d = next_pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            req_addr_q <= RESET_ADDR;
            next_pc_q  <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            next_pc_q  <= next_pc_d;
        end
    end

    assign fq.o_mem_req  = (state_q == S_REQ) || (state_q == S_DROP);
    assign fq.o_mem_addr = req_addr_q;
    assign fq.o_valid    = !fifo_empty;
    assign fq.o_bus      = fifo_empty ? '0 : fetch_bus_t'(fifo_rdata);

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue (RESET_ADDR=0x100, DEPTH=4).
// Inputs change #1 after posedge; outputs checked there too.
module tb_rv_fetch_queue;
    import rv_fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_target;
    logic        pc_select;
    int          n_vec = 0;
    int          n_err = 0;

    rv_fetch_queue_if fq ();

    rv_fetch_queue #(
        .RESET_ADDR (32'h0000_0100),
        .DEPTH      (4)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_pc_target (pc_target),
        .i_pc_select (pc_select),
        .fq          (fq.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ack, input logic [31:0] data,
                       input logic sel, input logic [31:0] tgt,
                       input logic rdy);
        fq.i_mem_ack  = ack;
        fq.i_mem_data = data;
        pc_select     = sel;
        pc_target     = tgt;
        fq.i_ready    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 64'(fq.o_valid), 64'd1);
        chk({tag, ".bus"}, fq.o_bus, {pc, mdat(pc)});
    endtask

    task automatic chk_req(input string tag, input logic [31:0] a);
        chk({tag, ".req"}, 64'(fq.o_mem_req), 64'd1);
        chk({tag, ".addr"}, 64'(fq.o_mem_addr), 64'(a));
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst.req", 64'(fq.o_mem_req), 64'd0);
        chk("rst.valid", 64'(fq.o_valid), 64'd0);
        chk("rst.bus", fq.o_bus, 64'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk_req("rel", 32'h100);

        // Streaming: ack one cycle after each request, decode always ready
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk_req("t1.wait", 32'h100 + 4 * i);
            chk("t1.empty", 64'(fq.o_valid), 64'd0);
            cyc(1, mdat(32'h100 + 4 * i), 0, 0, 1);
            chk_head("t1.head", 32'h100 + 4 * i);
            chk_req("t1.next", 32'h104 + 4 * i);
        end

        // Reset while a request to 0x10C is pending, head 0x108 queued
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("t6.req", 64'(fq.o_mem_req), 64'd0);
        chk("t6.valid", 64'(fq.o_valid), 64'd0);
        chk("t6.bus", fq.o_bus, 64'd0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk_req("t6.first", 32'h100);

        // Fill with decode stalled
        for (int k = 0; k < 4; k++) begin
            cyc(1, mdat(32'h100 + 4 * k), 0, 0, 0);
            chk_head("t2.head", 32'h100);
            if (k < 3) chk_req("t2.req", 32'h104 + 4 * k);
        end
        chk("t2.full.req", 64'(fq.o_mem_req), 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t2.hold.req", 64'(fq.o_mem_req), 64'd0);
        cyc(0, 0, 0, 0, 1);
        chk_req("t2.pop", 32'h110);
        chk_head("t2.pop", 32'h104);
        cyc(1, mdat(32'h110), 0, 0, 0);
        chk("t2.refill.req", 64'(fq.o_mem_req), 64'd0);
        chk_head("t2.refill", 32'h104);

        // Redirect from a full idle queue with a same-cycle pop
        cyc(0, 0, 1, 32'h40, 1);
        chk("t5.valid", 64'(fq.o_valid), 64'd0);
        chk("t5.bus", fq.o_bus, 64'd0);
        chk_req("t5.req", 32'h40);
        cyc(1, mdat(32'h40), 0, 0, 1);
        chk_head("t5.head", 32'h40);
        chk_req("t5.next", 32'h44);

        // Redirect during a slow request: old response dropped
        cyc(0, 0, 0, 0, 1);
        chk("t3.pop", 64'(fq.o_valid), 64'd0);
        cyc(0, 0, 1, 32'h2000, 1);
        chk_req("t3.drop", 32'h44);
        cyc(0, 0, 0, 0, 1);
        chk_req("t3.wait", 32'h44);
        chk("t3.wait.valid", 64'(fq.o_valid), 64'd0);
        cyc(1, mdat(32'h44), 0, 0, 1);
        chk("t3.stale", 64'(fq.o_valid), 64'd0);
        chk_req("t3.new", 32'h2000);
        cyc(0, 0, 0, 0, 1);
        cyc(1, mdat(32'h2000), 0, 0, 1);
        chk_head("t3.head", 32'h2000);
        chk_req("t3.next", 32'h2004);

        // Redirect in the same cycle as an ack
        cyc(1, mdat(32'h2004), 1, 32'h2000, 1);
        chk("t4.valid", 64'(fq.o_valid), 64'd0);
        chk("t4.bus", fq.o_bus, 64'd0);
        chk_req("t4.req", 32'h2000);
        cyc(0, 0, 0, 0, 1);
        chk("t4.empty", 64'(fq.o_valid), 64'd0);
        cyc(1, mdat(32'h2000), 0, 0, 1);
        chk_head("t4.head", 32'h2000);

        // Double redirect while dropping, then address wrap
        cyc(0, 0, 1, 32'h500, 1);
        chk_req("w.drop", 32'h2004);
        chk("w.valid", 64'(fq.o_valid), 64'd0);
        cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
        chk_req("w.drop2", 32'h2004);
        cyc(1, 32'hDEAD_BEEF, 0, 0, 1);
        chk("w.stale", 64'(fq.o_valid), 64'd0);
        chk_req("w.tgt", 32'hFFFF_FFFC);
        cyc(1, mdat(32'hFFFF_FFFC), 0, 0, 1);
        chk_head("w.head", 32'hFFFF_FFFC);
        chk_req("w.wrap", 32'h0);
        cyc(1, mdat(32'h0), 0, 0, 1);
        chk_head("w.zero", 32'h0);
        chk_req("w.after", 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
